// File: rtl/gf180mcu_osu_sc_12t_serial_add_ctrl.sv
// Bit-serial add sequencer driving one shared external full-adder cell, LSB first.
// Optional subtract mode when GF180MCU_OSU_SC_SERIAL_SUB_EN is defined (adds SUB port).
module gf180mcu_osu_sc_12t_serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] OPA,
   input  logic [WIDTH-1:0] OPB,
   input  logic             CIN,
`ifdef GF180MCU_OSU_SC_SERIAL_SUB_EN
   input  logic             SUB,
`endif
   output logic             FA_A,
   output logic             FA_B,
   output logic             FA_CI,
   input  logic             FA_S,
   input  logic             FA_CO,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, res;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             run, last, accept;
   logic [WIDTH-1:0] b_ld;
   logic             c_ld;

`ifdef GF180MCU_OSU_SC_SERIAL_SUB_EN
   // Subtract as A + ~B + 1; CIN is ignored in that mode.
   assign b_ld = SUB ? ~OPB : OPB;
   assign c_ld = SUB | CIN;
`else
   assign b_ld = OPB;
   assign c_ld = CIN;
`endif

   assign run       = (state == RUN);
   assign last      = run && (cnt == CW'(WIDTH - 1));
   assign IN_READY  = (state == IDLE);
   assign OUT_VALID = (state == DONE);
   assign accept    = IN_VALID && IN_READY;

   // Adder inputs are gated outside RUN to keep the shared cell quiet.
   assign FA_A  = run & a_sh[0];
   assign FA_B  = run & b_sh[0];
   assign FA_CI = run & carry;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (IN_VALID) state_nxt = RUN;
         RUN:     if (last) state_nxt = DONE;
         DONE:    if (OUT_READY) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         a_sh  <= '0;
         b_sh  <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         SUM   <= '0;
         COUT  <= 1'b0;
      end else if (accept) begin
         a_sh  <= OPA;
         b_sh  <= b_ld;
         carry <= c_ld;
         cnt   <= '0;
      end else if (run) begin
         a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
         res   <= {FA_S, res[WIDTH-1:1]};
         carry <= FA_CO;
         if (last) begin
            cnt  <= '0;
            SUM  <= {FA_S, res[WIDTH-1:1]};
            COUT <= FA_CO;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_serial_add_ctrl.sv
// Directed bench for the serial add sequencer with a behavioural full-adder cell.
module tb_gf180mcu_osu_sc_12t_serial_add_ctrl;
   localparam int WIDTH = 8;

   logic             CLK = 1'b0;
   logic             RN = 1'b0;
   logic             IN_VALID = 1'b0;
   logic             IN_READY;
   logic [WIDTH-1:0] OPA = '0, OPB = '0;
   logic             CIN = 1'b0;
   logic             SUB = 1'b0;
   logic             FA_A, FA_B, FA_CI, FA_S, FA_CO;
   logic             OUT_VALID;
   logic             OUT_READY = 1'b0;
   logic [WIDTH-1:0] SUM;
   logic             COUT;

   int vec = 0;
   int err = 0;

   always #5 CLK = ~CLK;

   assign FA_S  = FA_A ^ FA_B ^ FA_CI;
   assign FA_CO = (FA_A & FA_B) | (FA_A & FA_CI) | (FA_B & FA_CI);

   gf180mcu_osu_sc_12t_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .CLK(CLK), .RN(RN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .OPA(OPA), .OPB(OPB), .CIN(CIN),
`ifdef GF180MCU_OSU_SC_SERIAL_SUB_EN
      .SUB(SUB),
`endif
      .FA_A(FA_A), .FA_B(FA_B), .FA_CI(FA_CI), .FA_S(FA_S), .FA_CO(FA_CO),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .SUM(SUM), .COUT(COUT)
   );

   // Presents operands for one accept edge and waits (bounded) for OUT_VALID.
   // Returns the latency plus the FA_A / FA_CI values seen in each RUN cycle.
   task automatic run_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic ci, input logic sub, output int lat,
                          output logic [WIDTH-1:0] fa_a_seq, output logic [WIDTH-1:0] fa_ci_seq);
      @(negedge CLK);
      IN_VALID = 1'b1; OPA = a; OPB = b; CIN = ci; SUB = sub;
      @(posedge CLK);
      @(negedge CLK);
      IN_VALID = 1'b0;
      lat = 0; fa_a_seq = '0; fa_ci_seq = '0;
      while (!OUT_VALID && lat < 40) begin
         if (lat < WIDTH) begin
            fa_a_seq[lat]  = FA_A;
            fa_ci_seq[lat] = FA_CI;
         end
         @(posedge CLK);
         lat++;
         @(negedge CLK);
      end
   endtask

   task automatic handshake();
      @(negedge CLK);
      OUT_READY = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      OUT_READY = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      vec++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin err++;
         $display("FAIL reset_hs: IN_READY=%b OUT_VALID=%b want 1 0", IN_READY, OUT_VALID); end
      vec++; if ({FA_A, FA_B, FA_CI} !== 3'b000 || SUM !== 8'h00 || COUT !== 1'b0) begin err++;
         $display("FAIL reset_out: FA=%b SUM=%h COUT=%b want 000 00 0", {FA_A, FA_B, FA_CI}, SUM, COUT); end
      @(negedge CLK); RN = 1'b1;
   endtask

   task automatic test_basic_add();
      int lat; logic [WIDTH-1:0] sa, sc;
      run_add(8'h5A, 8'h3C, 1'b0, 1'b0, lat, sa, sc);
      vec++; if (lat !== WIDTH) begin err++; $display("FAIL add_latency: got %0d want %0d", lat, WIDTH); end
      vec++; if (SUM !== 8'h96 || COUT !== 1'b0) begin err++;
         $display("FAIL add_5a_3c: SUM=%h COUT=%b want 96 0", SUM, COUT); end
      vec++; if ({FA_A, FA_B, FA_CI} !== 3'b000) begin err++;
         $display("FAIL fa_gate_done: FA=%b want 000", {FA_A, FA_B, FA_CI}); end
      handshake();
      vec++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin err++;
         $display("FAIL add_handshake: IN_READY=%b OUT_VALID=%b want 1 0", IN_READY, OUT_VALID); end
      vec++; if (SUM !== 8'h96) begin err++; $display("FAIL sum_hold_idle: SUM=%h want 96", SUM); end
   endtask

   task automatic test_carry();
      int lat; logic [WIDTH-1:0] sa, sc;
      run_add(8'hFF, 8'h01, 1'b0, 1'b0, lat, sa, sc);
      vec++; if (SUM !== 8'h00 || COUT !== 1'b1) begin err++;
         $display("FAIL add_ff_01: SUM=%h COUT=%b want 00 1", SUM, COUT); end
      vec++; if (sc !== 8'hFE) begin err++; $display("FAIL fa_ci_seq: got %b want 11111110", sc); end
      handshake();
      run_add(8'hFF, 8'hFF, 1'b1, 1'b0, lat, sa, sc);
      vec++; if (SUM !== 8'hFF || COUT !== 1'b1) begin err++;
         $display("FAIL add_ff_ff_c1: SUM=%h COUT=%b want ff 1", SUM, COUT); end
      vec++; if (lat !== WIDTH) begin err++; $display("FAIL carry_latency: got %0d want %0d", lat, WIDTH); end
      handshake();
   endtask

   task automatic test_fa_sequence();
      int lat; logic [WIDTH-1:0] sa, sc;
      run_add(8'h81, 8'h00, 1'b0, 1'b0, lat, sa, sc);
      vec++; if (sa !== 8'h81) begin err++; $display("FAIL fa_a_seq: got %b want 10000001", sa); end
      vec++; if (SUM !== 8'h81 || COUT !== 1'b0) begin err++;
         $display("FAIL add_81_00: SUM=%h COUT=%b want 81 0", SUM, COUT); end
      handshake();
   endtask

   task automatic test_backpressure();
      int lat; logic [WIDTH-1:0] sa, sc;
      run_add(8'h12, 8'h34, 1'b1, 1'b0, lat, sa, sc);
      IN_VALID = 1'b1; OPA = 8'hAA; OPB = 8'hAA;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); @(negedge CLK);
         vec++; if (SUM !== 8'h47 || COUT !== 1'b0 || OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin err++;
            $display("FAIL backpressure_%0d: SUM=%h COUT=%b OV=%b IR=%b want 47 0 1 0",
                     i, SUM, COUT, OUT_VALID, IN_READY); end
      end
      OUT_READY = 1'b1;
      @(posedge CLK); @(negedge CLK);
      OUT_READY = 1'b0; IN_VALID = 1'b0;
      vec++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || SUM !== 8'h47) begin err++;
         $display("FAIL bp_release: IR=%b OV=%b SUM=%h want 1 0 47", IN_READY, OUT_VALID, SUM); end
   endtask

   task automatic test_reset_mid_run();
      int lat; logic [WIDTH-1:0] sa, sc;
      @(negedge CLK);
      IN_VALID = 1'b1; OPA = 8'hF0; OPB = 8'h0F; CIN = 1'b0; SUB = 1'b0;
      @(posedge CLK); @(negedge CLK);
      IN_VALID = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RN = 1'b0;
      #1;
      vec++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || {FA_A, FA_B, FA_CI} !== 3'b000 || SUM !== 8'h00) begin
         err++; $display("FAIL reset_mid_run: IR=%b OV=%b FA=%b SUM=%h want 1 0 000 00",
                         IN_READY, OUT_VALID, {FA_A, FA_B, FA_CI}, SUM); end
      @(negedge CLK); RN = 1'b1;
      run_add(8'h01, 8'h01, 1'b0, 1'b0, lat, sa, sc);
      vec++; if (SUM !== 8'h02 || COUT !== 1'b0 || lat !== WIDTH) begin err++;
         $display("FAIL add_after_reset: SUM=%h COUT=%b lat=%0d want 02 0 %0d", SUM, COUT, lat, WIDTH); end
      handshake();
   endtask

`ifdef GF180MCU_OSU_SC_SERIAL_SUB_EN
   task automatic test_sub();
      int lat; logic [WIDTH-1:0] sa, sc;
      run_add(8'h10, 8'h01, 1'b0, 1'b1, lat, sa, sc);
      vec++; if (SUM !== 8'h0F || COUT !== 1'b1) begin err++;
         $display("FAIL sub_10_01: SUM=%h COUT=%b want 0f 1", SUM, COUT); end
      handshake();
      run_add(8'h01, 8'h02, 1'b0, 1'b1, lat, sa, sc);
      vec++; if (SUM !== 8'hFF || COUT !== 1'b0) begin err++;
         $display("FAIL sub_01_02: SUM=%h COUT=%b want ff 0", SUM, COUT); end
      handshake();
   endtask
`endif

   initial begin
      test_reset();
      test_basic_add();
      test_carry();
      test_fa_sequence();
      test_backpressure();
      test_reset_mid_run();
`ifdef GF180MCU_OSU_SC_SERIAL_SUB_EN
      test_sub();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
